// File: rtl/plb_slave_pkg.sv
// Shared PLB slave definitions: transfer size codes, responder FSM states and
// the helpers that turn a size code into a beat count.
package plb_slave_pkg;

    localparam logic [3:0] SIZE_SINGLE = 4'd0;
    localparam logic [3:0] SIZE_LINE4  = 4'd1;
    localparam logic [3:0] SIZE_LINE8  = 4'd2;

    localparam logic [1:0] SSIZE_64 = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        ERR_TERM
    } state_t;

    function automatic logic sizeOk(input logic [3:0] size);
        return (size == SIZE_SINGLE) || (size == SIZE_LINE4) || (size == SIZE_LINE8);
    endfunction

    // Beats minus one; doubles as the word-in-line wrap mask.
    function automatic logic [2:0] lineMask(input logic [3:0] size);
        case (size)
            SIZE_LINE4: return 3'd3;
            SIZE_LINE8: return 3'd7;
            default:    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/plb_slave_mem_ram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port,
// written so synthesis maps it onto block RAM.
module plb_slave_mem_ram #(
    parameter int LOG_DEPTH = 9
) (
    input  logic                 CLK,
    input  logic [LOG_DEPTH-1:0] addr,
    input  logic [7:0]           we,
    input  logic [63:0]          wrData,
    output logic [63:0]          rdData
);

    logic [63:0] mem [2**LOG_DEPTH];

    // NOTE: the array and the read register have no reset; a reset port would stop
    // block-RAM inference, and contents must survive RST_N anyway.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
        rdData <= mem[addr];
    end

endmodule

// File: rtl/plb_slave_mem.sv
// PLB slave memory target: decodes an address window and serves single-beat and
// 4/8-word line transfers from an internal 64-bit RAM.
module plb_slave_mem
    import plb_slave_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h8000_0000,
    parameter int          LOG_DEPTH  = 9
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        PLB_PAValid,
    input  logic        PLB_RNW,
    input  logic [31:0] PLB_ABus,
    input  logic [7:0]  PLB_BE,
    input  logic [3:0]  PLB_size,
    input  logic [63:0] PLB_wrDBus,
    output logic        Sl_addrAck,
    output logic [1:0]  Sl_SSize,
    output logic        Sl_wait,
    output logic        Sl_rdDAck,
    output logic [63:0] Sl_rdDBus,
    output logic [2:0]  Sl_rdWdAddr,
    output logic        Sl_rdComp,
    output logic        Sl_wrDAck,
    output logic        Sl_wrComp,
    output logic        Sl_MBusy,
    output logic        Sl_MErr
);

    state_t state, nextState;

    logic                 rnwQ;
    logic [LOG_DEPTH-1:0] wordQ;
    logic [7:0]           beQ;
    logic [3:0]           sizeQ;
    logic [2:0]           beatCnt;

    logic                 hit;
    logic                 lastBeat;
    logic [2:0]           mask;
    logic [2:0]           startIdx;
    logic [2:0]           rdOffset;
    logic [2:0]           ramOffset;
    logic [LOG_DEPTH-1:0] ramAddr;
    logic [7:0]           ramWe;
    logic [63:0]          ramRdData;
    logic                 unusedAbusLsbs;

    // The window is size-aligned, so a hit is an equality test on the bits above it.
    assign hit            = PLB_ABus[31:LOG_DEPTH+3] == C_BASEADDR[31:LOG_DEPTH+3];
    assign unusedAbusLsbs = ^PLB_ABus[2:0];

    assign mask     = lineMask(sizeQ);
    assign lastBeat = beatCnt == mask;
    assign startIdx = wordQ[2:0] & mask;

    // The RAM read is one cycle ahead of the beat on the bus, hence the +1 in RD_DATA.
    assign rdOffset  = (startIdx + beatCnt + 3'(state == RD_DATA)) & mask;
    assign ramOffset = (state == WR_DATA) ? beatCnt : rdOffset;
    assign ramAddr   = (wordQ & ~LOG_DEPTH'(mask)) | LOG_DEPTH'(ramOffset);
    assign ramWe     = (state != WR_DATA)       ? 8'h00 :
                       (sizeQ == SIZE_SINGLE)   ? beQ   : 8'hFF;

    assign Sl_SSize = SSIZE_64;
    assign Sl_wait  = 1'b0;
    assign Sl_MBusy = state != IDLE;

    plb_slave_mem_ram #(
        .LOG_DEPTH(LOG_DEPTH)
    ) u_ram (
        .CLK   (CLK),
        .addr  (ramAddr),
        .we    (ramWe),
        .wrData(PLB_wrDBus),
        .rdData(ramRdData)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rnwQ    <= 1'b0;
            wordQ   <= '0;
            beQ     <= '0;
            sizeQ   <= '0;
            beatCnt <= '0;
        end else begin
            if (state == IDLE && PLB_PAValid && hit) begin
                rnwQ  <= PLB_RNW;
                wordQ <= PLB_ABus[LOG_DEPTH+2:3];
                beQ   <= PLB_BE;
                sizeQ <= PLB_size;
            end
            if ((state == RD_DATA || state == WR_DATA) && !lastBeat) begin
                beatCnt <= beatCnt + 3'd1;
            end else begin
                beatCnt <= '0;
            end
        end
    end

    // NOTE: every output and nextState gets a default first so no path infers a latch.
    always_comb begin
        nextState   = state;
        Sl_addrAck  = 1'b0;
        Sl_rdDAck   = 1'b0;
        Sl_rdDBus   = '0;
        Sl_rdWdAddr = '0;
        Sl_rdComp   = 1'b0;
        Sl_wrDAck   = 1'b0;
        Sl_wrComp   = 1'b0;
        Sl_MErr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (PLB_PAValid && hit) nextState = ACK;
            end
            ACK: begin
                Sl_addrAck = 1'b1;
                if (!sizeOk(sizeQ)) nextState = ERR_TERM;
                else if (rnwQ)      nextState = RD_WAIT;
                else                nextState = WR_DATA;
            end
            RD_WAIT: begin
                nextState = RD_DATA;
            end
            RD_DATA: begin
                Sl_rdDAck   = 1'b1;
                Sl_rdDBus   = ramRdData;
                Sl_rdWdAddr = (startIdx + beatCnt) & mask;
                Sl_rdComp   = lastBeat;
                if (lastBeat) nextState = IDLE;
            end
            WR_DATA: begin
                Sl_wrDAck = 1'b1;
                Sl_wrComp = lastBeat;
                if (lastBeat) nextState = IDLE;
            end
            ERR_TERM: begin
                Sl_MErr   = 1'b1;
                Sl_rdDAck = rnwQ;
                Sl_rdComp = rnwQ;
                Sl_wrDAck = !rnwQ;
                Sl_wrComp = !rnwQ;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_plb_slave_mem.sv
// Bench for plb_slave_mem: a transaction-level model expands each request into
// the expected per-cycle output trace, compared every cycle on the falling edge.
module tb_plb_slave_mem;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          LOG_DEPTH = 9;

    logic        CLK         = 1'b0;
    logic        RST_N       = 1'b0;
    logic        PLB_PAValid = 1'b0;
    logic        PLB_RNW     = 1'b0;
    logic [31:0] PLB_ABus    = '0;
    logic [7:0]  PLB_BE      = '0;
    logic [3:0]  PLB_size    = '0;
    logic [63:0] PLB_wrDBus  = '0;

    logic        Sl_addrAck;
    logic [1:0]  Sl_SSize;
    logic        Sl_wait;
    logic        Sl_rdDAck;
    logic [63:0] Sl_rdDBus;
    logic [2:0]  Sl_rdWdAddr;
    logic        Sl_rdComp;
    logic        Sl_wrDAck;
    logic        Sl_wrComp;
    logic        Sl_MBusy;
    logic        Sl_MErr;

    plb_slave_mem #(
        .C_BASEADDR(BASE),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PLB_PAValid(PLB_PAValid),
        .PLB_RNW    (PLB_RNW),
        .PLB_ABus   (PLB_ABus),
        .PLB_BE     (PLB_BE),
        .PLB_size   (PLB_size),
        .PLB_wrDBus (PLB_wrDBus),
        .Sl_addrAck (Sl_addrAck),
        .Sl_SSize   (Sl_SSize),
        .Sl_wait    (Sl_wait),
        .Sl_rdDAck  (Sl_rdDAck),
        .Sl_rdDBus  (Sl_rdDBus),
        .Sl_rdWdAddr(Sl_rdWdAddr),
        .Sl_rdComp  (Sl_rdComp),
        .Sl_wrDAck  (Sl_wrDAck),
        .Sl_wrComp  (Sl_wrComp),
        .Sl_MBusy   (Sl_MBusy),
        .Sl_MErr    (Sl_MErr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        addrAck;
        logic        mBusy;
        logic        rdDAck;
        logic        rdComp;
        logic        wrDAck;
        logic        wrComp;
        logic        mErr;
        logic [2:0]  rdWdAddr;
        logic [63:0] rdDBus;
    } cyc_t;

    typedef struct packed {
        logic [2:0]  wd;
        logic [63:0] data;
    } beat_t;

    cyc_t        expQ [$];
    beat_t       rdLog [$];
    logic [63:0] model [int];
    int          checks  = 0;
    int          errors  = 0;
    int          cycleNo = 0;
    int          lineWd [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic cyc_t mk(input logic ack, input logic busy, input logic rdAck,
                                input logic rdCmp, input logic wrAck, input logic wrCmp,
                                input logic err, input logic [2:0] wd, input logic [63:0] d);
        cyc_t c;
        c = {ack, busy, rdAck, rdCmp, wrAck, wrCmp, err, wd, d};
        return c;
    endfunction

    // Empty queue means the slave must be idle (reset values).
    always @(negedge CLK) begin
        cyc_t actC;
        cyc_t expC;
        cycleNo++;
        actC = {Sl_addrAck, Sl_MBusy, Sl_rdDAck, Sl_rdComp, Sl_wrDAck, Sl_wrComp,
                Sl_MErr, Sl_rdWdAddr, Sl_rdDBus};
        expC = '0;
        if (expQ.size() > 0) expC = expQ.pop_front();
        check($sformatf("cycle %0d outputs", cycleNo), 96'(actC), 96'(expC));
        check($sformatf("cycle %0d SSize/wait", cycleNo), 96'({Sl_SSize, Sl_wait}), 96'(3'b010));
        if (Sl_rdDAck) rdLog.push_back({Sl_rdWdAddr, Sl_rdDBus});
    end

    // Issues one request in an idle cycle and queues the full expected trace.
    task automatic request(input logic rnw, input logic [31:0] addr, input logic [3:0] size,
                           input logic [7:0] be, input logic [63:0] data0);
        int          n;
        int          word;
        int          lineBase;
        int          first;
        int          idx;
        logic        ok;
        logic [63:0] cur;
        ok       = (size <= 4'd2);
        n        = (size == 4'd1) ? 4 : (size == 4'd2) ? 8 : 1;
        word     = int'((addr - BASE) >> 3);
        first    = word % n;
        lineBase = word - first;
        expQ.push_back('0);
        expQ.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'd0, 64'd0));
        if (!ok) begin
            expQ.push_back(mk(0, 1, rnw, rnw, !rnw, !rnw, 1, 3'd0, 64'd0));
        end else if (rnw) begin
            expQ.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 64'd0));
            for (int k = 0; k < n; k++) begin
                idx = (first + k) % n;
                expQ.push_back(mk(0, 1, 1, k == n - 1, 0, 0, 0, 3'(idx), model[lineBase + idx]));
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                expQ.push_back(mk(0, 1, 0, 0, 1, k == n - 1, 0, 3'd0, 64'd0));
            end
            if (n == 1) begin
                cur = model.exists(word) ? model[word] : 64'd0;
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) cur[8*b +: 8] = data0[8*b +: 8];
                end
                model[word] = cur;
            end else begin
                for (int k = 0; k < n; k++) model[lineBase + k] = data0 + 64'(k);
            end
        end
        PLB_RNW     = rnw;
        PLB_ABus    = addr;
        PLB_size    = size;
        PLB_BE      = be;
        PLB_PAValid = 1'b1;
        @(posedge CLK);
        #1;
        PLB_PAValid = 1'b0;
        if (!rnw) begin
            for (int k = 0; k < n; k++) begin
                @(posedge CLK);
                #1;
                PLB_wrDBus = data0 + 64'(k);
            end
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        check("trace drained", 96'(expQ.size()), 96'(0));
        expQ.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkSingle(input string name, input logic [63:0] data);
        check({name, " beats"}, 96'(rdLog.size()), 96'(1));
        if (rdLog.size() > 0) check({name, " data"}, 96'(rdLog[0]), 96'({3'd0, data}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset outputs",
              96'({Sl_addrAck, Sl_MBusy, Sl_rdDAck, Sl_wrDAck, Sl_MErr, Sl_SSize, Sl_rdDBus}),
              96'({5'b0, 2'b01, 64'd0}));
        RST_N = 1'b1;
        waitDrain();

        request(1'b0, 32'h8000_0010, 4'd0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        waitDrain();
        rdLog.delete();
        request(1'b1, 32'h8000_0010, 4'd0, 8'h00, 64'd0);
        waitDrain();
        checkSingle("single read", 64'h0123_4567_89AB_CDEF);

        request(1'b0, 32'h8000_0010, 4'd0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        waitDrain();
        rdLog.delete();
        request(1'b1, 32'h8000_0010, 4'd0, 8'h00, 64'd0);
        waitDrain();
        checkSingle("byte enable merge", 64'h0123_4567_FFFF_FFFF);

        request(1'b0, 32'h8000_0040, 4'd2, 8'h00, 64'd0);
        waitDrain();
        rdLog.delete();
        request(1'b1, 32'h8000_0068, 4'd2, 8'h00, 64'd0);
        waitDrain();
        check("line8 beats", 96'(rdLog.size()), 96'(8));
        for (int i = 0; i < 8 && i < rdLog.size(); i++) begin
            check($sformatf("line8 beat %0d", i), 96'(rdLog[i]),
                  96'({3'(lineWd[i]), 64'(lineWd[i])}));
        end

        PLB_RNW     = 1'b1;
        PLB_size    = 4'd0;
        PLB_PAValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            PLB_ABus = (i < 10) ? 32'h7FFF_FFF8 : 32'h8000_1000;
            @(posedge CLK);
            #1;
        end
        PLB_PAValid = 1'b0;
        waitDrain();

        rdLog.delete();
        request(1'b1, 32'h8000_0010, 4'd4, 8'h00, 64'd0);
        waitDrain();
        checkSingle("unsupported read", 64'd0);

        request(1'b0, 32'h8000_0010, 4'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        waitDrain();
        rdLog.delete();
        request(1'b1, 32'h8000_0010, 4'd0, 8'h00, 64'd0);
        waitDrain();
        checkSingle("unsupported write keeps ram", 64'h0123_4567_FFFF_FFFF);

        request(1'b1, 32'h8000_0040, 4'd1, 8'h00, 64'd0);
        repeat (4) @(posedge CLK);
        #1;
        check("beat 3 before reset", 96'({Sl_rdDAck, Sl_rdWdAddr, Sl_rdDBus}),
              96'({1'b1, 3'd2, 64'd2}));
        #1;
        RST_N = 1'b0;
        expQ.delete();
        #1;
        check("async reset outputs",
              96'({Sl_addrAck, Sl_MBusy, Sl_rdDAck, Sl_rdComp, Sl_MErr, Sl_SSize, Sl_rdDBus}),
              96'({5'b0, 2'b01, 64'd0}));
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        waitDrain();
        rdLog.delete();
        request(1'b1, 32'h8000_0010, 4'd0, 8'h00, 64'd0);
        waitDrain();
        checkSingle("read after reset", 64'h0123_4567_FFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
